cap_err_sched: RTL and testbench

Synthesizable scheduler that sequences CHERI capability-fault injection in the CHERIoT-Ibex DV testbench. It shares one injection "slot" between NREQ injectors: LSU cap-check, PCC fetch-check and CSR/jump-check injectors. The block decides when an injection is armed and which injector owns it, supplies the per-injection seed, and counts completed, dropped and failed injections. It sits in the tb top next to the injectors and observes the core's instruction-retire and ISR indications.

---
 rtl/cheri_dv_pkg.sv | 28 ++
 rtl/dv_lfsr32.sv | 33 +++
 rtl/cap_err_sched.sv | 190 +++++++++++++++++++
 tb/tb_cap_err_sched.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cheri_dv_pkg.sv
// Shared definitions for the CHERI capability-fault injection scheduler.
//   sched_state_e : scheduler FSM states
//   LFSR_TAPS     : Galois feedback polynomial of the 32-bit seed LFSR
//   NREQ_MAX      : largest supported number of injector requesters
//   rate_mask()   : low LFSR bits that must be zero for an injection "hit"
//   sat_inc16()   : saturating 16-bit increment used by the event counters
package cheri_dv_pkg;

    localparam int          NREQ_MAX  = 8;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_COOL   = 2'd3
    } sched_state_e;

    // Rate r tests bits [7-r:0], i.e. probability 2^-(8-r).
    function automatic logic [7:0] rate_mask(input logic [2:0] rate);
        return 8'hFF >> rate;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

endpackage

// File: rtl/dv_lfsr32.sv
// Free-running 32-bit Galois LFSR (right-shifting, feedback LFSR_TAPS).
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset, loads SEED
//   lfsr_o out  current LFSR state, advances every cycle out of reset
module dv_lfsr32
    import cheri_dv_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] lfsr_o
);

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/cap_err_sched.sv
// Capability-fault injection scheduler: shares one injection slot between
// NREQ injectors, arms one of them (round-robin) on a random retire, hands
// out a seed and keeps completed / dropped / failed injection counts.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   err_rate_i[2:0]      0 = never, else hit probability 2^-(8-rate)
//   err_enable_i         global enable
//   instr_done_i         instruction retire pulse
//   in_isr_i             core in ISR: no new grant is issued
//   req_i/active_i/failed_i[NREQ-1:0]  per-injector request / forcing / failure
//   grant_o[NREQ-1:0]    one-hot arm, seed_o[31:0] seed for the armed injection
//   inj_cnt_o, drop_cnt_o, fail_cnt_o  saturating event counters
//   fail_o               sticky failure / protocol-violation flag
module cap_err_sched
    import cheri_dv_pkg::*;
#(
    parameter int          NREQ      = 3,
    parameter int          COOLDOWN  = 4,
    parameter logic [31:0] LFSR_SEED = 32'h1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2:0]      err_rate_i,
    input  logic            err_enable_i,
    input  logic            instr_done_i,
    input  logic            in_isr_i,
    input  logic [NREQ-1:0] req_i,
    input  logic [NREQ-1:0] active_i,
    input  logic [NREQ-1:0] failed_i,
    output logic [NREQ-1:0] grant_o,
    output logic [31:0]     seed_o,
    output logic [15:0]     inj_cnt_o,
    output logic [15:0]     drop_cnt_o,
    output logic [15:0]     fail_cnt_o,
    output logic            fail_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    sched_state_e    state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [31:0]     seed_q, seed_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic [3:0]      cool_q, cool_d;
    logic            flag_q, flag_d;
    logic            fail_q, fail_d;
    logic [15:0]     inj_cnt_q, inj_cnt_d;
    logic [15:0]     drop_cnt_q, drop_cnt_d;
    logic [15:0]     fail_cnt_q, fail_cnt_d;

    logic [31:0]     lfsr;
    logic            hit;
    logic [NREQ-1:0] pick_oh;
    logic [PW-1:0]   pick_idx;
    logic [PW-1:0]   rr_next;
    logic            pick_found;
    logic            gnt_active;
    logic            gnt_failed;
    logic            stray_active;

    dv_lfsr32 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .lfsr_o (lfsr)
    );

    assign hit = err_enable_i && (err_rate_i != 3'd0) &&
                 ((lfsr[7:0] & rate_mask(err_rate_i)) == 8'd0);

    // Round-robin: first requester at or after rr_q, wrapping modulo NREQ.
    always_comb begin
        pick_oh    = '0;
        pick_idx   = rr_q;
        pick_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            int idx;
            idx = (int'(rr_q) + i) % NREQ;
            if (!pick_found && req_i[idx]) begin
                pick_found   = 1'b1;
                pick_oh[idx] = 1'b1;
                pick_idx     = PW'(idx);
            end
        end
        rr_next = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
    end

    // Only the granted injector's active/failed lines matter; any active
    // line outside the grant is a protocol violation.
    assign gnt_active   = |(grant_q & active_i);
    assign gnt_failed   = |(grant_q & failed_i);
    assign stray_active = |(active_i & ~grant_q);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        seed_d     = seed_q;
        rr_d       = rr_q;
        cool_d     = cool_q;
        flag_d     = flag_q;
        inj_cnt_d  = inj_cnt_q;
        drop_cnt_d = drop_cnt_q;
        fail_cnt_d = fail_cnt_q;
        fail_d     = fail_q | stray_active;

        unique case (state_q)
            ST_IDLE: begin
                if (instr_done_i && !in_isr_i && pick_found && hit) begin
                    grant_d = pick_oh;
                    seed_d  = lfsr;
                    rr_d    = rr_next;
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // A simultaneous retire loses to active: the injection started.
                if (gnt_active) begin
                    state_d = ST_ACTIVE;
                end else if (instr_done_i || !err_enable_i) begin
                    drop_cnt_d = sat_inc16(drop_cnt_q);
                    grant_d    = '0;
                    cool_d     = '0;
                    state_d    = ST_COOL;
                end
            end
            ST_ACTIVE: begin
                if (gnt_failed) begin
                    flag_d = 1'b1;
                    fail_d = 1'b1;
                end
                if (!gnt_active) begin
                    inj_cnt_d = sat_inc16(inj_cnt_q);
                    if (flag_q || gnt_failed) begin
                        fail_cnt_d = sat_inc16(fail_cnt_q);
                    end
                    flag_d  = 1'b0;
                    grant_d = '0;
                    cool_d  = '0;
                    state_d = ST_COOL;
                end
            end
            ST_COOL: begin
                // COOL always lasts at least one cycle, COOLDOWN cycles otherwise.
                if (int'(cool_q) + 1 >= COOLDOWN) begin
                    state_d = ST_IDLE;
                end else begin
                    cool_d = cool_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            seed_q     <= '0;
            rr_q       <= '0;
            cool_q     <= '0;
            flag_q     <= 1'b0;
            fail_q     <= 1'b0;
            inj_cnt_q  <= '0;
            drop_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            seed_q     <= seed_d;
            rr_q       <= rr_d;
            cool_q     <= cool_d;
            flag_q     <= flag_d;
            fail_q     <= fail_d;
            inj_cnt_q  <= inj_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign grant_o    = grant_q;
    assign seed_o     = seed_q;
    assign inj_cnt_o  = inj_cnt_q;
    assign drop_cnt_o = drop_cnt_q;
    assign fail_cnt_o = fail_cnt_q;
    assign fail_o     = fail_q;

endmodule

// File: tb/tb_cap_err_sched.sv
module tb_cap_err_sched;

    localparam int          NREQ     = 3;
    localparam int          COOLDOWN = 4;
    localparam logic [31:0] SEED     = 32'h1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  err_rate = 3'd0;
    logic        err_en = 1'b0;
    logic        done = 1'b0;
    logic        isr = 1'b0;
    logic [2:0]  req = 3'b0;
    logic [2:0]  act = 3'b0;
    logic [2:0]  fl = 3'b0;
    logic [2:0]  grant_o;
    logic [31:0] seed_o;
    logic [15:0] inj_cnt_o, drop_cnt_o, fail_cnt_o;
    logic        fail_o;

    always #5 clk = ~clk;

    cap_err_sched #(
        .NREQ      (NREQ),
        .COOLDOWN  (COOLDOWN),
        .LFSR_SEED (SEED)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .err_rate_i   (err_rate),
        .err_enable_i (err_en),
        .instr_done_i (done),
        .in_isr_i     (isr),
        .req_i        (req),
        .active_i     (act),
        .failed_i     (fl),
        .grant_o      (grant_o),
        .seed_o       (seed_o),
        .inj_cnt_o    (inj_cnt_o),
        .drop_cnt_o   (drop_cnt_o),
        .fail_cnt_o   (fail_cnt_o),
        .fail_o       (fail_o)
    );

    int n_vec = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: who owns the slot, what phase the injection is in,
    // how many cooldown cycles remain, and the event totals.
    int unsigned m_lfsr;
    int          m_owner;      // -1 = slot free
    bit          m_waiting;    // granted, injector not started yet
    bit          m_running;    // injector forcing
    int          m_run_cycles;
    int          m_cool_left;
    int          m_next;       // round-robin start position
    int unsigned m_seed;
    int          m_inj, m_drop, m_fcnt;
    bit          m_fail, m_this_failed;
    bit          fail_arm;

    // Grant-sequence observation
    logic [2:0]  prev_grant;
    int          zero_run;
    bit          seen_grant;
    logic [2:0]  gseq[$];

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    function automatic int cool_len();
        return (COOLDOWN == 0) ? 1 : COOLDOWN;
    endfunction

    task automatic model_reset();
        m_lfsr = SEED; m_owner = -1; m_waiting = 0; m_running = 0; m_run_cycles = 0;
        m_cool_left = 0; m_next = 0; m_seed = 0; m_inj = 0; m_drop = 0; m_fcnt = 0;
        m_fail = 0; m_this_failed = 0;
        prev_grant = 3'b0; zero_run = 0; seen_grant = 0; gseq.delete();
    endtask

    task automatic model_step();
        int  r;
        bit  hit;
        r   = int'(err_rate);
        hit = err_en && (r != 0) && ((m_lfsr % (32'd1 << (8 - r))) == 0);
        for (int i = 0; i < NREQ; i++)
            if (act[i] && i != m_owner) m_fail = 1;
        if (m_waiting) begin
            if (act[m_owner]) begin
                m_waiting = 0; m_running = 1; m_run_cycles = 0;
            end else if (done || !err_en) begin
                m_drop = sat(m_drop); m_owner = -1; m_waiting = 0; m_cool_left = cool_len();
            end
        end else if (m_running) begin
            if (fl[m_owner]) begin m_this_failed = 1; m_fail = 1; end
            if (!act[m_owner]) begin
                m_inj = sat(m_inj);
                if (m_this_failed) m_fcnt = sat(m_fcnt);
                m_this_failed = 0; m_owner = -1; m_running = 0; m_cool_left = cool_len();
            end else begin
                m_run_cycles++;
            end
        end else if (m_cool_left > 0) begin
            m_cool_left--;
        end else if (done && !isr && req != 0 && hit) begin
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (m_next + k) % NREQ;
                if (m_owner < 0 && req[c]) m_owner = c;
            end
            m_seed = m_lfsr; m_next = (m_owner + 1) % NREQ; m_waiting = 1;
        end
        m_lfsr = (m_lfsr >> 1) ^ ((m_lfsr & 1) != 0 ? 32'h8020_0003 : 32'h0);
    endtask

    task automatic compare_all();
        logic [2:0] eg;
        eg = (m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
        chk("grant", {29'b0, grant_o}, {29'b0, eg});
        chk("seed", seed_o, m_seed);
        chk("inj_cnt", {16'b0, inj_cnt_o}, m_inj);
        chk("drop_cnt", {16'b0, drop_cnt_o}, m_drop);
        chk("fail_cnt", {16'b0, fail_cnt_o}, m_fcnt);
        chk("fail", {31'b0, fail_o}, {31'b0, m_fail});
        if (grant_o != 3'b0 && prev_grant == 3'b0) begin
            if (seen_grant)
                chk("gap", (zero_run >= COOLDOWN + 1) ? 32'd1 : 32'd0, 32'd1);
            gseq.push_back(grant_o);
            seen_grant = 1;
            zero_run = 0;
        end
        if (grant_o == 3'b0) zero_run++;
        prev_grant = grant_o;
    endtask

    // mode 0 random, 1 echo injector, 2 never-start injector, 3 quiet, 4 stray active
    task automatic gen_inputs(input int mode);
        act = 3'b0; fl = 3'b0;
        case (mode)
            0: begin
                done = 1'($urandom_range(0, 1));
                req  = 3'($urandom);
                isr  = ($urandom_range(0, 7) == 0);
                err_en = ($urandom_range(0, 15) != 0);
                if (m_waiting && $urandom_range(0, 1) == 1) act[m_owner] = 1'b1;
                if (m_running && $urandom_range(0, 2) != 0) act[m_owner] = 1'b1;
                if (m_running && $urandom_range(0, 7) == 0) fl[m_owner] = 1'b1;
                if ($urandom_range(0, 63) == 0) act[$urandom_range(0, 2)] = 1'b1;
            end
            1: begin
                done = 1'b1; req = 3'b111; isr = 1'b0;
                if (m_waiting) act[m_owner] = 1'b1;
                if (m_running && m_run_cycles == 0) act[m_owner] = 1'b1;
                if (m_running && fail_arm) begin fl[m_owner] = 1'b1; fail_arm = 0; end
            end
            2: begin done = 1'b1; req = 3'b111; isr = 1'b0; end
            3: begin done = 1'b0; end
            default: begin done = 1'b0; act = 3'b010; end
        endcase
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic run_cycles(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            gen_inputs(mode);
            @(posedge clk);
            model_step();
            #1;
            compare_all();
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        act = 3'b0; fl = 3'b0; done = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        fail_arm = 0;
        do_reset();
        chk("rst_grant", {29'b0, grant_o}, 32'd0);
        chk("rst_seed", seed_o, 32'd0);
        chk("rst_inj", {16'b0, inj_cnt_o}, 32'd0);
        chk("rst_drop", {16'b0, drop_cnt_o}, 32'd0);
        chk("rst_fcnt", {16'b0, fail_cnt_o}, 32'd0);
        chk("rst_fail", {31'b0, fail_o}, 32'd0);
        $display("phase reset checked");

        // Rate 0, then disabled: no grants at all.
        err_rate = 3'd0; err_en = 1'b1;
        run_cycles(500, 2);
        err_rate = 3'd7; err_en = 1'b0;
        run_cycles(500, 2);
        chk("off_inj", {16'b0, inj_cnt_o}, 32'd0);
        chk("off_drop", {16'b0, drop_cnt_o}, 32'd0);
        chk("off_seen", {31'b0, seen_grant}, 32'd0);
        $display("phase disabled: 1000 retires, %0d grants", gseq.size());

        // Stray active pulse in IDLE.
        run_cycles(1, 4);
        run_cycles(2, 3);
        chk("stray_fail", {31'b0, fail_o}, 32'd1);
        chk("stray_inj", {16'b0, inj_cnt_o}, 32'd0);
        $display("phase stray active done");

        // Rotation with echoing injectors.
        do_reset();
        err_rate = 3'd7; err_en = 1'b1;
        run_cycles(200, 1);
        if (gseq.size() >= 4) begin
            chk("rot0", {29'b0, gseq[0]}, 32'd1);
            chk("rot1", {29'b0, gseq[1]}, 32'd2);
            chk("rot2", {29'b0, gseq[2]}, 32'd4);
            chk("rot3", {29'b0, gseq[3]}, 32'd1);
        end else begin
            chk("rot_count", gseq.size(), 32'd4);
        end
        chk("rot_inj", {16'b0, inj_cnt_o}, gseq.size() - ((grant_o != 3'b0) ? 1 : 0));
        chk("rot_drop", {16'b0, drop_cnt_o}, 32'd0);
        $display("phase rotation: %0d grants, inj_cnt %0d", gseq.size(), inj_cnt_o);

        // Drop: granted injector never starts, next retire abandons.
        do_reset();
        guard = 0;
        while (m_owner < 0 && guard < 100) begin run_cycles(1, 2); guard++; end
        chk("drop_granted", {29'b0, grant_o}, 32'd1);
        run_cycles(1, 2);
        chk("drop_cnt1", {16'b0, drop_cnt_o}, 32'd1);
        chk("drop_gnt0", {29'b0, grant_o}, 32'd0);
        run_cycles(COOLDOWN + 2, 3);
        $display("phase drop: drop_cnt %0d", drop_cnt_o);

        // Failure in first injection, second injection clean.
        do_reset();
        fail_arm = 1;
        guard = 0;
        while (m_inj < 2 && guard < 200) begin run_cycles(1, 1); guard++; end
        chk("flt_fail", {31'b0, fail_o}, 32'd1);
        chk("flt_fcnt", {16'b0, fail_cnt_o}, 32'd1);
        chk("flt_inj", {16'b0, inj_cnt_o}, 32'd2);
        $display("phase failure: fail_cnt %0d inj_cnt %0d", fail_cnt_o, inj_cnt_o);

        // Asynchronous reset while ACTIVE.
        guard = 0;
        while (!m_running && guard < 200) begin run_cycles(1, 1); guard++; end
        chk("ar_running", {31'b0, m_running}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_grant", {29'b0, grant_o}, 32'd0);
        chk("ar_inj", {16'b0, inj_cnt_o}, 32'd0);
        chk("ar_fcnt", {16'b0, fail_cnt_o}, 32'd0);
        chk("ar_fail", {31'b0, fail_o}, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        guard = 0;
        while (m_owner < 0 && guard < 100) begin run_cycles(1, 1); guard++; end
        chk("ar_first", {29'b0, grant_o}, 32'd1);
        $display("phase async reset: first grant %b seed %h", grant_o, seed_o);

        // Randomized traffic against the model.
        do_reset();
        for (int b = 0; b < 20; b++) begin
            err_rate = (b % 4 == 0) ? 3'd7 : 3'($urandom_range(0, 7));
            run_cycles(200, 0);
        end
        $display("phase random: inj %0d drop %0d fail %0d", inj_cnt_o, drop_cnt_o, fail_cnt_o);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
